// File: rtl/flag_branch_unit.sv
// flag_branch_unit: {Z,V,N} flag register with class-selective writes and a
// three-state branch evaluator that stalls on pending flag writes. Rev 1.0
`default_nettype none

module flag_branch_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        flag_wr,
  input  logic [1:0]  flag_class,
  input  logic [15:0] alu_result,
  input  logic        alu_ovfl,
  input  logic        flag_pending,
  input  logic        br_req,
  input  logic [2:0]  br_cond,
  output logic        br_ack,
  output logic        br_taken,
  output logic        br_stall,
  output logic [2:0]  flags
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ACK  = 2'd2
  } state_t;

  state_t     state;
  logic [2:0] flags_next;
  logic       result_zero;
  logic       cond_met;
  logic       eff_z;
  logic       eff_v;
  logic       eff_n;

  assign result_zero = (alu_result == 16'h0000);

  // flags_next doubles as the bypassed "effective" flags for evaluation
  always_comb begin
    flags_next = flags;
    if (flag_wr) begin
      case (flag_class)
        2'b01:   flags_next = {result_zero, alu_ovfl, alu_result[15]};
        2'b10:   flags_next = {result_zero, flags[1:0]};
        default: flags_next = flags;
      endcase
    end
  end

  assign eff_z = flags_next[2];
  assign eff_v = flags_next[1];
  assign eff_n = flags_next[0];

  always_comb begin
    cond_met = 1'b0;
    case (br_cond)
      3'b000:  cond_met = ~eff_z;
      3'b001:  cond_met = eff_z;
      3'b010:  cond_met = ~eff_z & ~eff_n;
      3'b011:  cond_met = eff_n;
      3'b100:  cond_met = eff_z | ~eff_n;
      3'b101:  cond_met = eff_n | eff_z;
      3'b110:  cond_met = eff_v;
      default: cond_met = 1'b1;
    endcase
  end

  // Stall is combinational so the requester sees it in the cycle it asks
  assign br_stall = ~rst & br_req &
                    (((state == IDLE) & flag_pending) | (state == WAIT));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      flags    <= 3'b000;
      br_ack   <= 1'b0;
      br_taken <= 1'b0;
    end else begin
      flags    <= flags_next;
      br_ack   <= 1'b0;
      br_taken <= 1'b0;
      case (state)
        IDLE: begin
          if (br_req) begin
            if (flag_pending) begin
              state <= WAIT;
            end else begin
              state    <= ACK;
              br_ack   <= 1'b1;
              br_taken <= cond_met;
            end
          end
        end
        WAIT: begin
          if (!br_req) begin
            state <= IDLE;
          end else if (flag_wr && !flag_pending) begin
            state    <= ACK;
            br_ack   <= 1'b1;
            br_taken <= cond_met;
          end
        end
        ACK:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire
